sa_skew_feeder: RTL and testbench
=================================

# sa_skew_feeder

Parametrised operand sequencer for the conv systolic array: buffers one weight vector, replays it a configurable number of passes while streaming input-feature-map words alongside, and drives LANES ifm/weight lanes with the one-cycle-per-lane diagonal skew the array requires. Sits between the on-chip operand buffers and the array's west/north edges. It replaces hand-written per-lane skew and replay logic, and adds runtime length/repeat configuration, bubble handling and error flagging.

## Interface
- DATA_WIDTH, 8, element width
- LANES, 3, array rows/columns fed (≥1)
- WLEN_MAX, 32, weight buffer depth (max vector length K)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  pulse: start job (sampled in IDLE only)
- cfg_wlen  in  $clog2(WLEN_MAX+1)  vector length K, legal 1..WLEN_MAX
- cfg_wrep  in  8  pass count P, legal 1..255
- w_in_valid / w_in_ready  in / out  1  weight load handshake
- w_in_data  in  LANES*DATA_WIDTH  one word per lane, lane i at bits [i*DW +: DW]
- ifm_in_valid / ifm_in_ready  in / out  1  ifm stream handshake
- ifm_in_data  in  LANES*DATA_WIDTH  lane-packed as above
- ifm_out, w_out  out  LANES*DATA_WIDTH  skewed lane data
- ifm_out_en, w_out_en  out  LANES  per-lane valid
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky config/protocol error

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE: cfg_start with legal cfg → latch K, P, clear err, go LOAD. Illegal cfg (K=0, K>WLEN_MAX, P=0) → set err, stay IDLE.
- LOAD: w_in_ready=1; each transfer writes buffer address 0..K-1 in order; transfer at address K-1 → RUN. Nothing driven on outputs.
- RUN: ifm_in_ready=1; each transfer pairs ifm_in_data with buffer word at replay index r. r runs 0..K-1 and wraps; pass counter p increments on wrap. Transfer at r=K-1, p=P-1 → DRAIN (or IDLE if LANES=1). Exactly K*P ifm words are consumed.
- ifm_in_valid low in RUN: bubble. r/p hold, lane-0 enables low for that slot; the bubble propagates down the skew like data.
- DRAIN: LANES-1 cycles flushing skew lines, then IDLE with done.
- cfg_start while busy: ignored, err set; job continues unaffected.
- Disabled lane slots carry data 0 (data zeroed on entry when en low).
- Buffer contents are not reset; they are rewritten by each LOAD.

## Timing
- Reset: all outputs 0 (data, enables, busy, done, err, readys); state IDLE; counters 0.
- Lane i of both ifm and w outputs = slot accepted at edge E, visible after edge E+i (lane 0 registered, +1 register per lane). ifm and w lanes are always aligned.
- Last RUN transfer at edge E0: DRAIN edges E0+1..E0+LANES-1; IDLE and done=1 after edge E0+LANES-1, i.e. done coincides with the final lane's final element.
- busy rises the cycle after an accepted start; falls with done.
- Back-to-back: cfg_start may be asserted in the done cycle (state IDLE) and is accepted.
- Async reset mid-job: immediate return to reset values; in-flight skew contents discarded.

## Structure
- Package sa_pkg: state enum, DATA_WIDTH default, lane-slice helper, clog2-derived counter widths.
- Sub-module sa_skew_line (params DATA_WIDTH, DEPTH): DEPTH-stage register chain carrying {en, data}; DEPTH=0 is a wire. Instantiated 2×LANES with DEPTH=i.
- Top holds FSM, buffer (reg array, combinational read), r/p counters, drain counter, lane-0 register stage.

## Test plan
- LANES=3, K=3, P=3, weights lane i = {i*10+1,+2,+3}, ifm = 1..9 continuous → lane0 ifm 1..9 after start+3 load cycles, lane2 same delayed 2; w lanes repeat 3 vectors 3×; done with final lane-2 element; 9 ifm transfers.
- Same job, ifm_in_valid low on transfers 4 and 7 → enables drop for exactly one slot per lane, staircased; weight/ifm pairing unchanged.
- LANES=1, K=1, P=1 → single slot, no DRAIN, done one cycle after ifm transfer.
- cfg_wlen=0, then cfg_wrep=0 → err=1, busy stays 0; next legal start clears err.
- cfg_start during RUN → err=1, output sequence identical to undisturbed run.
- rst_n low mid-RUN for one cycle → all outputs 0 immediately, IDLE; fresh job afterwards runs correctly.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types, defaults and width helpers for the systolic-array skew feeder.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int REP_W          = 8;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bit offset of a lane inside a lane-packed bus.
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Purpose: DEPTH-stage delay of one lane's {en, data}; DEPTH=0 degenerates to a wire.
// Latency: exactly DEPTH cycles.
// Backpressure: none, free-running shift; idle slots are stored as zero data.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_en,
    output logic [DATA_WIDTH-1:0] out_data
);
    if (DEPTH == 0) begin : g_wire
        assign out_en   = in_en;
        assign out_data = in_data;
    end else begin : g_pipe
        logic [DEPTH-1:0]      en_q;
        logic [DATA_WIDTH-1:0] dat_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                en_q <= '0;
                for (int s = 0; s < DEPTH; s++) begin
                    dat_q[s] <= '0;
                end
            end else begin
                en_q[0]  <= in_en;
                dat_q[0] <= in_en ? in_data : '0;
                for (int s = 1; s < DEPTH; s++) begin
                    en_q[s]  <= en_q[s-1];
                    dat_q[s] <= dat_q[s-1];
                end
            end
        end

        assign out_en   = en_q[DEPTH-1];
        assign out_data = dat_q[DEPTH-1];
    end
endmodule

// File: rtl/sa_skew_feeder.sv
// Purpose: load one weight vector, replay it P passes against streamed ifm words, drive diagonally skewed lanes.
// Latency: lane i of a slot accepted at edge E is visible after edge E+i; done lands with the last lane's final element.
// Backpressure: none downstream; w_in_ready / ifm_in_ready are pure state decodes, a low ifm_in_valid becomes a bubble.
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LANES      = 3,
    parameter int WLEN_MAX   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic [$clog2(WLEN_MAX+1)-1:0] cfg_wlen,
    input  logic [REP_W-1:0]              cfg_wrep,
    input  logic                          w_in_valid,
    output logic                          w_in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   w_in_data,
    input  logic                          ifm_in_valid,
    output logic                          ifm_in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   ifm_in_data,
    output logic [LANES*DATA_WIDTH-1:0]   ifm_out,
    output logic [LANES*DATA_WIDTH-1:0]   w_out,
    output logic [LANES-1:0]              ifm_out_en,
    output logic [LANES-1:0]              w_out_en,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int WL_W       = $clog2(WLEN_MAX + 1);
    localparam int IDX_W      = cnt_w(WLEN_MAX);
    localparam int DC_W       = cnt_w(LANES);
    localparam int BUS_W      = LANES * DATA_WIDTH;
    localparam int DRAIN_LAST = (LANES > 1) ? LANES - 2 : 0;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, k_last;
    logic [REP_W-1:0] pass, p_last;
    logic [DC_W-1:0]  drain_cnt;
    logic [BUS_W-1:0] wbuf [WLEN_MAX];
    logic             cfg_legal, start_ok, finish, w_xfer, ifm_xfer, idx_wrap;
    logic             slot_en;
    logic [BUS_W-1:0] slot_ifm, slot_w;

    assign cfg_legal    = (cfg_wlen != '0) && (cfg_wlen <= WL_W'(WLEN_MAX)) && (cfg_wrep != '0);
    assign w_in_ready   = (state == ST_LOAD);
    assign ifm_in_ready = (state == ST_RUN);
    assign busy         = (state != ST_IDLE);
    assign w_xfer       = w_in_valid && w_in_ready;
    assign ifm_xfer     = ifm_in_valid && ifm_in_ready;
    assign idx_wrap     = (idx == k_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_start && cfg_legal) begin
                    state_nxt = ST_LOAD;
                    start_ok  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_xfer && idx_wrap) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ifm_xfer && idx_wrap && (pass == p_last)) begin
                    // A single lane has no skew to flush.
                    if (LANES == 1) begin
                        state_nxt = ST_IDLE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DC_W'(DRAIN_LAST)) begin
                    state_nxt = ST_IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            pass      <= '0;
            k_last    <= '0;
            p_last    <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= finish;
            if (cfg_start) begin
                err <= busy ? 1'b1 : !cfg_legal;
            end
            // idx is the load address in LOAD and the replay index r in RUN.
            if (start_ok) begin
                k_last <= IDX_W'(cfg_wlen - WL_W'(1));
                p_last <= cfg_wrep - REP_W'(1);
                idx    <= '0;
                pass   <= '0;
            end else if (w_xfer || ifm_xfer) begin
                idx <= idx_wrap ? '0 : idx + IDX_W'(1);
                if (ifm_xfer && idx_wrap) begin
                    pass <= pass + REP_W'(1);
                end
            end
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DC_W'(1) : '0;
        end
    end

    // Weight storage is deliberately unreset; every job rewrites it during LOAD.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            wbuf[idx] <= w_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_en  <= 1'b0;
            slot_ifm <= '0;
            slot_w   <= '0;
        end else begin
            slot_en  <= ifm_xfer;
            slot_ifm <= ifm_xfer ? ifm_in_data : '0;
            slot_w   <= ifm_xfer ? wbuf[idx] : '0;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sa_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i)
        ) u_ifm_skew (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_en    (slot_en),
            .in_data  (slot_ifm[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .out_en   (ifm_out_en[i]),
            .out_data (ifm_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
        );

        sa_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (i)
        ) u_w_skew (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_en    (slot_en),
            .in_data  (slot_w[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .out_en   (w_out_en[i]),
            .out_data (w_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboarded bench for sa_skew_feeder: a 3-lane instance under random jobs plus a 1-lane instance.
module tb_sa_skew_feeder;
    localparam int DW  = 8;
    localparam int NL  = 3;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            cfg_start;
    logic [5:0]      cfg_wlen;
    logic [7:0]      cfg_wrep;
    logic            w_in_valid, w_in_ready, ifm_in_valid, ifm_in_ready;
    logic [NL*DW-1:0] w_in_data, ifm_in_data, ifm_out, w_out;
    logic [NL-1:0]   ifm_out_en, w_out_en;
    logic            busy, done, err;

    logic            b_cfg_start;
    logic [5:0]      b_cfg_wlen;
    logic [7:0]      b_cfg_wrep;
    logic            b_w_in_valid, b_w_in_ready, b_ifm_in_valid, b_ifm_in_ready;
    logic [DW-1:0]   b_w_in_data, b_ifm_in_data, b_ifm_out, b_w_out;
    logic [0:0]      b_ifm_out_en, b_w_out_en;
    logic            b_busy, b_done, b_err;

    sa_skew_feeder #(.DATA_WIDTH(DW), .LANES(NL), .WLEN_MAX(32)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_wlen(cfg_wlen), .cfg_wrep(cfg_wrep),
        .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_in_data(w_in_data),
        .ifm_in_valid(ifm_in_valid), .ifm_in_ready(ifm_in_ready), .ifm_in_data(ifm_in_data),
        .ifm_out(ifm_out), .w_out(w_out), .ifm_out_en(ifm_out_en), .w_out_en(w_out_en),
        .busy(busy), .done(done), .err(err)
    );

    sa_skew_feeder #(.DATA_WIDTH(DW), .LANES(1), .WLEN_MAX(32)) dut_one (
        .clk(clk), .rst_n(rst_n), .cfg_start(b_cfg_start), .cfg_wlen(b_cfg_wlen), .cfg_wrep(b_cfg_wrep),
        .w_in_valid(b_w_in_valid), .w_in_ready(b_w_in_ready), .w_in_data(b_w_in_data),
        .ifm_in_valid(b_ifm_in_valid), .ifm_in_ready(b_ifm_in_ready), .ifm_in_data(b_ifm_in_data),
        .ifm_out(b_ifm_out), .w_out(b_w_out), .ifm_out_en(b_ifm_out_en), .w_out_en(b_w_out_en),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    typedef struct {
        int            cyc;
        logic [DW-1:0] ifm;
        logic [DW-1:0] w;
    } exp_t;

    exp_t lq [NL][$];
    int   dq [$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int pending_cnt();
        int n = dq.size();
        for (int i = 0; i < NL; i++) n += lq[i].size();
        return n;
    endfunction

    // Monitor: each enabled lane slot must match the oldest expectation for that lane.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < NL; i++) begin
                if (ifm_out_en[i] || w_out_en[i]) begin
                    if (lq[i].size() == 0) begin
                        chk($sformatf("lane%0d_unexpected_en", i), {ifm_out_en[i], w_out_en[i]}, 2'b00);
                    end else begin
                        e = lq[i].pop_front();
                        chk($sformatf("lane%0d_time", i), cyc, e.cyc);
                        chk($sformatf("lane%0d_en_pair", i), {ifm_out_en[i], w_out_en[i]}, 2'b11);
                        chk($sformatf("lane%0d_ifm", i), ifm_out[i*DW +: DW], e.ifm);
                        chk($sformatf("lane%0d_w", i), w_out[i*DW +: DW], e.w);
                    end
                end else begin
                    chk($sformatf("lane%0d_idle_zero", i), {ifm_out[i*DW +: DW], w_out[i*DW +: DW]}, 16'h0);
                    if (lq[i].size() != 0 && lq[i][0].cyc <= cyc) begin
                        chk($sformatf("lane%0d_missing_en", i), ifm_out_en[i], 1'b1);
                        void'(lq[i].pop_front());
                    end
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("done_unexpected", done, 1'b0);
                else chk("done_time", cyc, dq.pop_front());
            end else if (dq.size() != 0 && dq[0] <= cyc) begin
                chk("done_missing", done, 1'b1);
                void'(dq.pop_front());
            end
        end
    end

    // Drives one job; the model pairs transfer j with weight vector j mod K and expects lane i at edge+i.
    task automatic run_job(input int k, input int p, input bit rnd, input int bub_a, input int bub_b,
                           input int bub_pct, input int stop, input bit poke);
        logic [NL*DW-1:0] wv [$];
        logic [NL*DW-1:0] iv [$];
        exp_t ex;
        int   se, e, j, li, stall, nb0;
        bit   a_used, b_used, bubble;
        a_used = 1'b0; b_used = 1'b0; nb0 = 0;
        for (int x = 0; x < k; x++) wv.push_back(rnd ? 24'($urandom) : {8'(21 + x), 8'(11 + x), 8'(1 + x)});
        for (int x = 0; x < k * p; x++) iv.push_back(rnd ? 24'($urandom) : {3{8'(x + 1)}});
        cfg_wlen = 6'(k); cfg_wrep = 8'(p); cfg_start = 1'b1;
        se = cyc + 1;
        @(posedge clk); #1 cfg_start = 1'b0;
        li = 0; stall = 0;
        while (li < k) begin
            w_in_valid = 1'b1; w_in_data = wv[li];
            @(negedge clk);
            if (li == 0 && stall == 0) begin
                chk("busy_after_start", busy, 1'b1);
                chk("err_after_legal_start", err, 1'b0);
            end
            if (w_in_ready) begin
                if (li == 0) chk("first_load_edge", cyc + 1, se + 1);
                li++;
            end else begin
                stall++;
                if (stall > 20) begin chk("w_ready_timeout", w_in_ready, 1'b1); break; end
            end
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        j = 0; stall = 0;
        while (j < k * p && j < stop) begin
            bubble = 1'b0;
            if (j == bub_a && !a_used) begin bubble = 1'b1; a_used = 1'b1; end
            else if (j == bub_b && !b_used) begin bubble = 1'b1; b_used = 1'b1; end
            else if (bub_pct > 0 && $urandom_range(99) < bub_pct) bubble = 1'b1;
            if (bubble && j == 0) nb0++;
            ifm_in_valid = !bubble;
            ifm_in_data  = bubble ? 24'($urandom) : iv[j];
            if (poke && j == 4) cfg_start = 1'b1;
            @(negedge clk);
            if (ifm_in_valid && ifm_in_ready) begin
                e = cyc + 1;
                if (j == 0) chk("first_run_edge", e, se + k + 1 + nb0);
                for (int i = 0; i < NL; i++) begin
                    ex.cyc = e + i;
                    ex.ifm = iv[j][i*DW +: DW];
                    ex.w   = wv[j % k][i*DW +: DW];
                    lq[i].push_back(ex);
                end
                if (j == k * p - 1) dq.push_back(e + NL - 1);
                j++; stall = 0;
            end else if (ifm_in_valid) begin
                stall++;
                if (stall > 20) begin chk("ifm_ready_timeout", ifm_in_ready, 1'b1); break; end
            end
            @(posedge clk); #1 cfg_start = 1'b0;
        end
        ifm_in_valid = 1'b0;
        cfg_start    = 1'b0;
        if (j == k * p) begin
            @(negedge clk); #1;
            chk("ready_drop_after_last", ifm_in_ready, 1'b0);
            for (int t = 0; t < 20 && pending_cnt() > 0; t++) begin
                @(negedge clk); #1;
            end
            chk("job_drained", pending_cnt(), 0);
            chk("busy_after_done", busy, 1'b0);
        end
    endtask

    task automatic bad_start(input string name, input int k, input int p);
        cfg_wlen = 6'(k); cfg_wrep = 8'(p); cfg_start = 1'b1;
        @(posedge clk); #1 cfg_start = 1'b0;
        @(negedge clk);
        chk({name, "_err"}, err, 1'b1);
        chk({name, "_busy"}, busy, 1'b0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (%0d checks so far)", n_chk);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_wlen = '0; cfg_wrep = '0;
        w_in_valid = 1'b0; w_in_data = '0; ifm_in_valid = 1'b0; ifm_in_data = '0;
        b_cfg_start = 1'b0; b_cfg_wlen = '0; b_cfg_wrep = '0;
        b_w_in_valid = 1'b0; b_w_in_data = '0; b_ifm_in_valid = 1'b0; b_ifm_in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {ifm_out, w_out, ifm_out_en, w_out_en, busy, done, err, w_in_ready, ifm_in_ready}, '0);
        chk("reset_outputs_one", {b_ifm_out, b_w_out, b_ifm_out_en, b_w_out_en, b_busy, b_done, b_err,
                                  b_w_in_ready, b_ifm_in_ready}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job(3, 3, 1'b0, -1, -1, 0, BIG, 1'b0);
        run_job(3, 3, 1'b0, 3, 6, 0, BIG, 1'b0);
        bad_start("wlen_zero", 0, 3);
        bad_start("wlen_over", 33, 3);
        bad_start("wrep_zero", 3, 0);
        run_job(3, 3, 1'b0, -1, -1, 0, BIG, 1'b1);
        chk("err_after_busy_start", err, 1'b1);
        run_job(32, 2, 1'b1, -1, -1, 20, BIG, 1'b0);
        run_job(1, 1, 1'b1, -1, -1, 0, BIG, 1'b0);
        for (int n = 0; n < 5; n++) begin
            run_job(int'($urandom_range(1, 8)), int'($urandom_range(1, 4)), 1'b1, -1, -1, 25, BIG, 1'b0);
        end

        run_job(4, 3, 1'b1, -1, -1, 0, 5, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < NL; i++) lq[i].delete();
        dq.delete();
        #1;
        chk("midrun_reset_outputs", {ifm_out, w_out, ifm_out_en, w_out_en, busy, done, err, w_in_ready, ifm_in_ready}, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(3, 2, 1'b1, -1, -1, 0, BIG, 1'b0);

        b_cfg_wlen = 6'd1; b_cfg_wrep = 8'd1; b_cfg_start = 1'b1;
        @(posedge clk); #1 b_cfg_start = 1'b0; b_w_in_valid = 1'b1; b_w_in_data = 8'h5A;
        @(negedge clk);
        chk("one_w_ready", b_w_in_ready, 1'b1);
        chk("one_busy", b_busy, 1'b1);
        @(posedge clk); #1 b_w_in_valid = 1'b0; b_ifm_in_valid = 1'b1; b_ifm_in_data = 8'hC3;
        @(negedge clk);
        chk("one_ifm_ready", b_ifm_in_ready, 1'b1);
        @(posedge clk); #1 b_ifm_in_valid = 1'b0;
        @(negedge clk);
        chk("one_ifm_out", {b_ifm_out_en, b_ifm_out}, {1'b1, 8'hC3});
        chk("one_w_out", {b_w_out_en, b_w_out}, {1'b1, 8'h5A});
        chk("one_done", b_done, 1'b1);
        chk("one_busy_end", b_busy, 1'b0);
        chk("one_ready_low", b_ifm_in_ready, 1'b0);
        @(negedge clk);
        chk("one_done_pulse", b_done, 1'b0);
        chk("one_en_clear", {b_ifm_out_en, b_w_out_en, b_ifm_out, b_w_out}, '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
